// File: rtl/i2s_pkg.sv
// Shared constants and enumerations for the I2S receive path.
package i2s_pkg;

    localparam int unsigned I2S_WIDTH = 24;

    typedef enum logic {
        CH_LEFT  = 1'b0,
        CH_RIGHT = 1'b1
    } i2s_ch_t;

    typedef enum logic {
        RX_IDLE,
        RX_SHIFT
    } i2s_rx_state_t;

endpackage

// File: rtl/i2s_rx_if.sv
// Left/right sample-pair stream with valid/ready handshake.
interface i2s_rx_if
    import i2s_pkg::*;
#(
    parameter int unsigned WIDTH = I2S_WIDTH
);

    logic [WIDTH-1:0] out_left;
    logic [WIDTH-1:0] out_right;
    logic             out_valid;
    logic             out_ready;

    modport master (
        output out_left,
        output out_right,
        output out_valid,
        input  out_ready
    );

    modport slave (
        input  out_left,
        input  out_right,
        input  out_valid,
        output out_ready
    );

endinterface

// File: rtl/i2s_rx_sync.sv
// Single-bit synchroniser into the clk domain with a registered rising-edge strobe.
module i2s_rx_sync #(
    parameter int unsigned STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic q_o,
    output logic rise_o
);

    logic [STAGES-1:0] chain_q;
    logic              prev_q;
    logic              rise_q;

    // Metastability chain: d_i enters at bit 0, leaves at the top bit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            chain_q <= '0;
        end else begin
            chain_q <= {chain_q[STAGES-2:0], d_i};
        end
    end

    assign q_o = chain_q[STAGES-1];

    // Previous-value register and registered rise strobe.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev_q <= 1'b0;
            rise_q <= 1'b0;
        end else begin
            prev_q <= q_o;
            rise_q <= q_o & ~prev_q;
        end
    end

    assign rise_o = rise_q;

endmodule

// File: rtl/i2s_rx.sv
// Oversampling I2S receiver: synchronises bck/ws/sd, deserialises MSB-first
// words and presents left/right pairs on a valid/ready stream.
// Optional feature macro: I2S_RX_FRAME_ERR_EN (word-length error flag).
module i2s_rx
    import i2s_pkg::*;
#(
    parameter int unsigned WIDTH       = I2S_WIDTH,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        bck,
    input  logic        ws,
    input  logic        sd,
    input  logic        invert,
    i2s_rx_if.master    bus,
    output logic        overrun,
    output logic        frame_err
);

    localparam int unsigned CW = $clog2(WIDTH + 1);

    logic          bck_s_unused;
    logic          bck_rise;
    logic          ws_s;
    logic          ws_rise_unused;
    logic          sd_s;
    logic          sd_rise_unused;

    i2s_rx_state_t    state_q;
    i2s_ch_t          ws_eff;
    i2s_ch_t          ws_last_q;
    logic             ws_change;
    logic [CW-1:0]    bitcnt_q;
    logic [CW-1:0]    bitcnt_d;
    logic [WIDTH-1:0] shreg_q;
    logic [WIDTH-1:0] shreg_d;
    logic [WIDTH-1:0] left_hold_q;
    logic             have_left_q;
    logic             pair_done_q;
    logic [WIDTH-1:0] pair_l_q;
    logic [WIDTH-1:0] pair_r_q;
    logic [WIDTH-1:0] out_left_q;
    logic [WIDTH-1:0] out_right_q;
    logic             out_valid_q;
    logic             overrun_q;

    i2s_rx_sync #(.STAGES(SYNC_STAGES)) u_sync_bck (
        .clk    (clk),
        .rst    (rst),
        .d_i    (bck),
        .q_o    (bck_s_unused),
        .rise_o (bck_rise)
    );

    i2s_rx_sync #(.STAGES(SYNC_STAGES)) u_sync_ws (
        .clk    (clk),
        .rst    (rst),
        .d_i    (ws),
        .q_o    (ws_s),
        .rise_o (ws_rise_unused)
    );

    i2s_rx_sync #(.STAGES(SYNC_STAGES)) u_sync_sd (
        .clk    (clk),
        .rst    (rst),
        .d_i    (sd),
        .q_o    (sd_s),
        .rise_o (sd_rise_unused)
    );

    assign ws_eff    = i2s_ch_t'(ws_s ^ invert);
    assign ws_change = (ws_eff != ws_last_q);

    // Shift register with the current bit inserted; counter saturating at WIDTH.
    always_comb begin
        shreg_d = shreg_q;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            if (bitcnt_q == CW'(i)) begin
                shreg_d[WIDTH-1-i] = sd_s;
            end
        end
        bitcnt_d = (bitcnt_q == CW'(WIDTH)) ? bitcnt_q : bitcnt_q + CW'(1);
    end

`ifdef I2S_RX_FRAME_ERR_EN
    logic frame_err_q;
`endif

    // Word-framing FSM: advances on bit-clock rises only.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= RX_IDLE;
            ws_last_q   <= CH_LEFT;
            bitcnt_q    <= '0;
            shreg_q     <= '0;
            left_hold_q <= '0;
            have_left_q <= 1'b0;
            pair_done_q <= 1'b0;
            pair_l_q    <= '0;
            pair_r_q    <= '0;
`ifdef I2S_RX_FRAME_ERR_EN
            frame_err_q <= 1'b0;
`endif
        end else begin
            pair_done_q <= 1'b0;
            if (bck_rise) begin
                ws_last_q <= ws_eff;
                case (state_q)
                    RX_IDLE: begin
                        if (ws_change) begin
                            bitcnt_q <= '0;
                            shreg_q  <= '0;
                            state_q  <= RX_SHIFT;
                        end
                    end
                    RX_SHIFT: begin
                        if (ws_change) begin
`ifdef I2S_RX_FRAME_ERR_EN
                            // The LSB is not yet counted, so a full word shows WIDTH-1 here.
                            if (bitcnt_q != CW'(WIDTH - 1)) begin
                                frame_err_q <= 1'b1;
                            end
`endif
                            if (ws_last_q == CH_LEFT) begin
                                left_hold_q <= shreg_d;
                                have_left_q <= 1'b1;
                            end else if (have_left_q) begin
                                pair_done_q <= 1'b1;
                                pair_l_q    <= left_hold_q;
                                pair_r_q    <= shreg_d;
                                have_left_q <= 1'b0;
                            end
                            shreg_q  <= '0;
                            bitcnt_q <= '0;
                        end else begin
                            shreg_q  <= shreg_d;
                            bitcnt_q <= bitcnt_d;
                        end
                    end
                    default: state_q <= RX_IDLE;
                endcase
            end
        end
    end

    // Output holding stage: load on pair completion, drop on handshake.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_left_q  <= '0;
            out_right_q <= '0;
            out_valid_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else if (pair_done_q) begin
            out_left_q  <= pair_l_q;
            out_right_q <= pair_r_q;
            out_valid_q <= 1'b1;
            if (out_valid_q && !bus.out_ready) begin
                overrun_q <= 1'b1;
            end
        end else if (out_valid_q && bus.out_ready) begin
            out_valid_q <= 1'b0;
        end
    end

    assign bus.out_left  = out_left_q;
    assign bus.out_right = out_right_q;
    assign bus.out_valid = out_valid_q;
    assign overrun       = overrun_q;

`ifdef I2S_RX_FRAME_ERR_EN
    assign frame_err = frame_err_q;
`else
    assign frame_err = 1'b0;
`endif

endmodule

// File: tb/tb_i2s_rx.sv
// Directed self-checking bench for i2s_rx: tx-style serial stream, bck = clk/26.
module tb_i2s_rx;

    logic clk = 1'b0;
    logic rst;
    logic bck;
    logic ws;
    logic sd;
    logic invert;
    logic overrun;
    logic frame_err;

    int checks = 0;
    int errors = 0;

`ifdef I2S_RX_FRAME_ERR_EN
    localparam logic EXP_FE_SHORT = 1'b1;
`else
    localparam logic EXP_FE_SHORT = 1'b0;
`endif

    i2s_rx_if #(.WIDTH(24)) bus ();

    i2s_rx #(.WIDTH(24), .SYNC_STAGES(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .bck       (bck),
        .ws        (ws),
        .sd        (sd),
        .invert    (invert),
        .bus       (bus),
        .overrun   (overrun),
        .frame_err (frame_err)
    );

    always #5 clk = ~clk;

    // One bit slot: data/ws set at the falling edge, 13 clk low, 13 clk high.
    task automatic drive_bit(input logic ws_eff, input logic b);
        ws = ws_eff ^ invert;
        sd = b;
        repeat (13) @(posedge clk);
        #1 bck = 1'b1;
        repeat (13) @(posedge clk);
        #1 bck = 1'b0;
    endtask

    // First 'count' bits of an MSB-first word; ws flips on the LSB slot.
    task automatic send_bits(input logic ch, input logic [23:0] data, input int nbits, input int count);
        for (int i = 0; i < count; i++) begin
            drive_bit((i == nbits - 1) ? ~ch : ch, data[nbits-1-i]);
        end
    endtask

    task automatic send_word(input logic ch, input logic [23:0] data, input int nbits);
        send_bits(ch, data, nbits, nbits);
    endtask

    // Leading ws edge plus one full right word, so the receiver is aligned to a left word.
    task automatic preamble();
        drive_bit(1'b1, 1'b0);
        send_word(1'b1, 24'h000000, 24);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bck = 1'b0;
        ws  = 1'b0;
        sd  = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic wait_valid(input string name);
        int n = 0;
        while (bus.out_valid !== 1'b1 && n < 40) begin
            @(posedge clk);
            #1;
            n++;
        end
        checks++;
        if (bus.out_valid !== 1'b1) begin
            errors++;
            $display("FAIL %s_valid_timeout: got %b expected 1", name, bus.out_valid);
        end
    endtask

    task automatic accept();
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1 bus.out_ready = 1'b0;
    endtask

    task automatic test_reset();
        #20;
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", bus.out_valid); end
        checks++; if (bus.out_left !== 24'h0) begin errors++; $display("FAIL reset_left: got %h expected 000000", bus.out_left); end
        checks++; if (bus.out_right !== 24'h0) begin errors++; $display("FAIL reset_right: got %h expected 000000", bus.out_right); end
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun: got %b expected 0", overrun); end
        checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL reset_frame_err: got %b expected 0", frame_err); end
    endtask

    task automatic test_basic();
        invert = 1'b0;
        bus.out_ready = 1'b0;
        do_reset();
        preamble();
        send_word(1'b0, 24'hA5A5A5, 24);
        send_bits(1'b1, 24'h5A5A5A, 24, 23);
        // final right LSB slot driven by hand to measure latency from the bck rise
        ws = 1'b0 ^ invert;
        sd = 1'b0;
        repeat (13) @(posedge clk);
        #1 bck = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk);
            #1;
            checks++;
            if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL basic_latency_early%0d: got %b expected 0", k, bus.out_valid); end
        end
        @(posedge clk);
        #1;
        checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL basic_latency_rise: got %b expected 1", bus.out_valid); end
        repeat (8) @(posedge clk);
        #1 bck = 1'b0;
        repeat (13) @(posedge clk);
        #1;
        checks++; if (bus.out_left !== 24'hA5A5A5) begin errors++; $display("FAIL basic_left: got %h expected a5a5a5", bus.out_left); end
        checks++; if (bus.out_right !== 24'h5A5A5A) begin errors++; $display("FAIL basic_right: got %h expected 5a5a5a", bus.out_right); end
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL basic_overrun: got %b expected 0", overrun); end
        checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL basic_frame_err: got %b expected 0", frame_err); end
        checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL basic_valid_held: got %b expected 1", bus.out_valid); end
        accept();
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL basic_valid_drop: got %b expected 0", bus.out_valid); end
    endtask

    task automatic test_invert();
        invert = 1'b1;
        bus.out_ready = 1'b0;
        do_reset();
        preamble();
        send_word(1'b0, 24'hA5A5A5, 24);
        send_word(1'b1, 24'h5A5A5A, 24);
        wait_valid("invert");
        checks++; if (bus.out_left !== 24'hA5A5A5) begin errors++; $display("FAIL invert_left: got %h expected a5a5a5", bus.out_left); end
        checks++; if (bus.out_right !== 24'h5A5A5A) begin errors++; $display("FAIL invert_right: got %h expected 5a5a5a", bus.out_right); end
        accept();
        invert = 1'b0;
    endtask

    task automatic test_overrun();
        invert = 1'b0;
        bus.out_ready = 1'b0;
        do_reset();
        preamble();
        send_word(1'b0, 24'h000001, 24);
        send_word(1'b1, 24'h000002, 24);
        send_word(1'b0, 24'h000003, 24);
        send_word(1'b1, 24'h000004, 24);
        wait_valid("overrun");
        checks++; if (bus.out_left !== 24'h000003) begin errors++; $display("FAIL overrun_left: got %h expected 000003", bus.out_left); end
        checks++; if (bus.out_right !== 24'h000004) begin errors++; $display("FAIL overrun_right: got %h expected 000004", bus.out_right); end
        checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL overrun_flag: got %b expected 1", overrun); end
    endtask

    task automatic test_midword_start();
        logic [23:0] junk;
        junk = 24'h3C3C3C;
        bus.out_ready = 1'b0;
        do_reset();
        for (int i = 14; i < 24; i++) begin
            drive_bit((i == 23) ? 1'b0 : 1'b1, junk[23-i]);
        end
        send_word(1'b0, 24'h111111, 24);
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL midword_no_early_valid: got %b expected 0", bus.out_valid); end
        send_word(1'b1, 24'h222222, 24);
        wait_valid("midword");
        checks++; if (bus.out_left !== 24'h111111) begin errors++; $display("FAIL midword_left: got %h expected 111111", bus.out_left); end
        checks++; if (bus.out_right !== 24'h222222) begin errors++; $display("FAIL midword_right: got %h expected 222222", bus.out_right); end
    endtask

    task automatic test_reset_mid();
        // the pair from the previous scenario is still pending here
        send_bits(1'b0, 24'hFFFFFF, 24, 10);
        @(posedge clk);
        #1 rst = 1'b1;
        #1;
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL rstmid_valid: got %b expected 0", bus.out_valid); end
        checks++; if (bus.out_left !== 24'h0) begin errors++; $display("FAIL rstmid_left: got %h expected 000000", bus.out_left); end
        checks++; if (bus.out_right !== 24'h0) begin errors++; $display("FAIL rstmid_right: got %h expected 000000", bus.out_right); end
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL rstmid_overrun: got %b expected 0", overrun); end
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        preamble();
        send_word(1'b0, 24'h0F0F0F, 24);
        send_word(1'b1, 24'hF0F0F0, 24);
        wait_valid("rstmid");
        checks++; if (bus.out_left !== 24'h0F0F0F) begin errors++; $display("FAIL rstmid_next_left: got %h expected 0f0f0f", bus.out_left); end
        checks++; if (bus.out_right !== 24'hF0F0F0) begin errors++; $display("FAIL rstmid_next_right: got %h expected f0f0f0", bus.out_right); end
        accept();
    endtask

    task automatic test_short_words();
        invert = 1'b0;
        bus.out_ready = 1'b0;
        do_reset();
        preamble();
        send_word(1'b0, 24'h00ABCD, 16);
        send_word(1'b1, 24'h001234, 16);
        wait_valid("short");
        checks++; if (bus.out_left !== 24'hABCD00) begin errors++; $display("FAIL short_left: got %h expected abcd00", bus.out_left); end
        checks++; if (bus.out_right !== 24'h123400) begin errors++; $display("FAIL short_right: got %h expected 123400", bus.out_right); end
        checks++; if (frame_err !== EXP_FE_SHORT) begin errors++; $display("FAIL short_frame_err: got %b expected %b", frame_err, EXP_FE_SHORT); end
    endtask

    initial begin
        rst           = 1'b1;
        bck           = 1'b0;
        ws            = 1'b0;
        sd            = 1'b0;
        invert        = 1'b0;
        bus.out_ready = 1'b0;
        test_reset();
        test_basic();
        test_invert();
        test_overrun();
        test_midword_start();
        test_reset_mid();
        test_short_words();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL global_timeout: simulation did not complete, got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
